// File: rtl/ripple_count_monitor.sv
// Monitors an asynchronous ripple counter: synchronises it, filters settling
// glitches, checks each settled value is a +1 step and counts wrap-arounds.
module ripple_count_monitor #(
    parameter int CNT_W         = 2,
    parameter int WRAP_W        = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              enable,
    output logic [CNT_W-1:0]  count_q,
    output logic              valid,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err,
    output logic              err_sticky
);

    localparam logic [3:0]       STAB_TARGET = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [CNT_W-1:0] s1;
    logic [CNT_W-1:0] s2;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] cand_next;
    logic [3:0]       stab;
    logic [3:0]       stab_next;
    logic             accept;
    logic [CNT_W-1:0] expected_next;
    logic             is_change;
    logic             is_legal_step;
    logic             is_wrap;

    // Two-flop synchroniser; keeps running while monitoring is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= count_in;
            s2 <= s1;
        end
    end

    // Any change of s2 restarts the stability count; acceptance fires only on
    // the edge where the count reaches its target, never while saturated.
    always_comb begin
        cand_next = s2;
        stab_next = stab;
        accept    = 1'b0;
        if (!enable) begin
            stab_next = 4'd0;
        end else if (s2 != cand) begin
            stab_next = 4'd1;
            accept    = (STAB_TARGET == 4'd1);
        end else if (stab < STAB_TARGET) begin
            stab_next = stab + 4'd1;
            accept    = ((stab + 4'd1) == STAB_TARGET);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= '0;
            stab <= 4'd0;
        end else begin
            cand <= cand_next;
            stab <= stab_next;
        end
    end

    always_comb begin
        expected_next = count_q + CNT_W'(1);
        is_change     = (cand_next != count_q);
        is_legal_step = (cand_next == expected_next);
        is_wrap       = is_legal_step && (count_q == CNT_MAX);
    end

    // The first acceptance after reset or re-enable only baselines count_q;
    // later ones are classified as legal step, wrap or illegal jump.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            valid      <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
            if (!enable) begin
                valid <= 1'b0;
            end else if (accept) begin
                if (!valid) begin
                    count_q <= cand_next;
                    valid   <= 1'b1;
                end else if (is_change) begin
                    count_q <= cand_next;
                    if (is_wrap) begin
                        wrap_pulse <= 1'b1;
                        wrap_count <= wrap_count + WRAP_W'(1);
                    end else if (!is_legal_step) begin
                        step_err   <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Scoreboard bench for ripple_count_monitor: each settled input pushes the
// expected outputs for the cycle they must appear, popped when that cycle comes.
module tb_ripple_count_monitor;

    localparam int CNT_W         = 2;
    localparam int WRAP_W        = 2;
    localparam int STABLE_CYCLES = 2;
    localparam int LAT           = 2 + STABLE_CYCLES;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              enable   = 1'b1;
    logic [CNT_W-1:0]  count_in = '0;
    logic [CNT_W-1:0]  count_q;
    logic              valid;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              step_err;
    logic              err_sticky;

    ripple_count_monitor #(
        .CNT_W(CNT_W),
        .WRAP_W(WRAP_W),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .count_in(count_in),
        .enable(enable),
        .count_q(count_q),
        .valid(valid),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count),
        .step_err(step_err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        int                due;
        logic [CNT_W-1:0]  cq;
        logic              v;
        logic              wp;
        logic              se;
        logic [WRAP_W-1:0] wc;
        logic              es;
    } exp_t;

    exp_t sb[$];

    int cyc     = 0;
    int checks  = 0;
    int passes  = 0;
    int wp_seen = 0;
    int se_seen = 0;
    int wp_exp  = 0;
    int se_exp  = 0;

    logic [CNT_W-1:0]  m_cq    = '0;
    logic [WRAP_W-1:0] m_wc    = '0;
    logic              m_valid = 1'b0;
    logic              m_es    = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    endtask

    task automatic pushRaw(input string tag, input int due, input logic [CNT_W-1:0] cq, input logic v,
                           input logic wp, input logic se, input logic [WRAP_W-1:0] wc, input logic es);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.cq  = cq;
        e.v   = v;
        e.wp  = wp;
        e.se  = se;
        e.wc  = wc;
        e.es  = es;
        sb.push_back(e);
    endtask

    // Model state on the due cycle, then pulses must be gone one cycle later.
    task automatic pushExp(input int due, input string tag, input logic wp, input logic se);
        pushRaw(tag, due, m_cq, m_valid, wp, se, m_wc, m_es);
        pushRaw({tag, "_after"}, due + 1, m_cq, m_valid, 1'b0, 1'b0, m_wc, m_es);
    endtask

    task automatic serviceScoreboard();
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.tag, "_due"}, cyc, e.due);
            checkOutput({e.tag, "_count_q"}, count_q, e.cq);
            checkOutput({e.tag, "_valid"}, valid, e.v);
            checkOutput({e.tag, "_wrap_pulse"}, wrap_pulse, e.wp);
            checkOutput({e.tag, "_step_err"}, step_err, e.se);
            checkOutput({e.tag, "_wrap_count"}, wrap_count, e.wc);
            checkOutput({e.tag, "_err_sticky"}, err_sticky, e.es);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (wrap_pulse) wp_seen++;
        if (step_err) se_seen++;
        serviceScoreboard();
    endtask

    // Drives a settled value and predicts the transaction-level outcome.
    task automatic applyStimulus(input logic [CNT_W-1:0] v, input int hold, input string tag);
        logic exp_wp;
        logic exp_se;
        exp_wp = 1'b0;
        exp_se = 1'b0;
        count_in = v;
        if (enable) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_cq    = v;
            end else if (v == m_cq + CNT_W'(1)) begin
                if (m_cq == {CNT_W{1'b1}}) begin
                    m_wc   = m_wc + WRAP_W'(1);
                    exp_wp = 1'b1;
                    wp_exp++;
                end
                m_cq = v;
            end else if (v != m_cq) begin
                m_cq   = v;
                m_es   = 1'b1;
                exp_se = 1'b1;
                se_exp++;
            end
            pushExp(cyc + LAT, tag, exp_wp, exp_se);
        end
        repeat (hold) tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count_q"}, count_q, 0);
        checkOutput({tag, "_valid"}, valid, 0);
        checkOutput({tag, "_wrap_pulse"}, wrap_pulse, 0);
        checkOutput({tag, "_wrap_count"}, wrap_count, 0);
        checkOutput({tag, "_step_err"}, step_err, 0);
        checkOutput({tag, "_err_sticky"}, err_sticky, 0);
    endtask

    // Releases reset with count_in at 0: baseline lands two edges later.
    task automatic releaseReset(input string tag);
        reset   = 1'b0;
        m_cq    = '0;
        m_wc    = '0;
        m_es    = 1'b0;
        m_valid = 1'b1;
        pushRaw({tag, "_pre"}, cyc + 1, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        pushExp(cyc + STABLE_CYCLES, tag, 1'b0, 1'b0);
        repeat (5) tick();
    endtask

    logic [WRAP_W-1:0] wrap_round_exp [4];

    initial begin
        wrap_round_exp[0] = 2'd1;
        wrap_round_exp[1] = 2'd2;
        wrap_round_exp[2] = 2'd3;
        wrap_round_exp[3] = 2'd0;

        repeat (3) tick();
        checkResetState("reset_hold");
        releaseReset("reset_base");

        applyStimulus(2'd1, 10, "step_1");
        applyStimulus(2'd2, 10, "step_2");
        applyStimulus(2'd3, 10, "step_3");
        applyStimulus(2'd0, 10, "step_wrap");
        checkOutput("steps_wrap_count", wrap_count, 1);
        checkOutput("steps_no_err", se_seen, 0);
        checkOutput("steps_one_wrap", wp_seen, 1);

        applyStimulus(2'd1, 10, "pre_glitch");
        count_in = 2'd3;
        tick();
        applyStimulus(2'd2, 10, "glitch_to_2");
        checkOutput("glitch_no_err", err_sticky, 0);

        applyStimulus(2'd3, 10, "to_3");
        applyStimulus(2'd0, 10, "wrap_2");
        applyStimulus(2'd1, 10, "pre_jump");
        applyStimulus(2'd3, 10, "jump_1_3");
        applyStimulus(2'd0, 10, "wrap_after_err");
        applyStimulus(2'd1, 10, "pre_disable");
        checkOutput("jump_sticky", err_sticky, 1);

        enable  = 1'b0;
        m_valid = 1'b0;
        tick();
        checkOutput("dis_valid_drop", valid, 0);
        applyStimulus(2'd2, 10, "dis_2");
        checkOutput("dis2_valid", valid, 0);
        checkOutput("dis2_count_q", count_q, 1);
        applyStimulus(2'd3, 10, "dis_3");
        checkOutput("dis3_valid", valid, 0);
        checkOutput("dis3_count_q", count_q, 1);
        applyStimulus(2'd1, 10, "dis_1");
        checkOutput("dis1_valid", valid, 0);
        checkOutput("dis1_count_q", count_q, 1);
        checkOutput("dis_wrap_count", wrap_count, m_wc);

        enable  = 1'b1;
        m_valid = 1'b1;
        pushRaw("reenable_pre", cyc + 1, m_cq, 1'b0, 1'b0, 1'b0, m_wc, m_es);
        pushExp(cyc + STABLE_CYCLES, "reenable_base", 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("phase1_wraps", wp_seen, wp_exp);
        checkOutput("phase1_errs", se_seen, se_exp);
        checkOutput("phase1_sticky", err_sticky, 1);

        reset = 1'b1;
        count_in = 2'd0;
        repeat (3) tick();
        checkResetState("reset2_hold");
        releaseReset("reset2_base");

        for (int r = 0; r < 4; r++) begin
            applyStimulus(2'd1, 10, "round_1");
            applyStimulus(2'd2, 10, "round_2");
            applyStimulus(2'd3, 10, "round_3");
            applyStimulus(2'd0, 10, "round_0");
            checkOutput("wrap_round", wrap_count, wrap_round_exp[r]);
        end

        applyStimulus(2'd1, 10, "pre_mid_1");
        applyStimulus(2'd2, 10, "pre_mid_2");
        applyStimulus(2'd3, 10, "pre_mid_3");
        applyStimulus(2'd0, 10, "pre_mid_wrap");
        applyStimulus(2'd1, 10, "pre_mid_base");
        checkOutput("pre_mid_wrap_count", wrap_count, 1);

        count_in = 2'd3;
        repeat (LAT - 1) tick();
        reset = 1'b1;
        tick();
        checkResetState("reset_mid_accept");
        tick();
        checkResetState("reset_mid_after");
        count_in = 2'd0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();

        checkOutput("final_wraps", wp_seen, wp_exp);
        checkOutput("final_errs", se_seen, se_exp);
        checkOutput("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
